countdown_sequencer: RTL and testbench

- Controller that sequences a WIDTH-bit down counter.
- Loads a start value, then starts, pauses and resumes the count.
- Decrements once per prescaled tick derived from CLOCK_50.
- Flags terminal count. Sits between board switches/keys and the count display, replacing the free-running divided-clock scheme with a single-clock, enable-based design.

---
 rtl/countdown_pkg.sv | 20 ++
 rtl/countdown_tick_gen.sv | 38 +++
 rtl/countdown_sequencer.sv | 157 +++++++++++++++
 tb/tb_countdown_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared constants for the countdown sequencer: FSM state codes and
// prescaler sizing.
package countdown_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOADED = 3'd1;
   localparam logic [STATE_W-1:0] ST_RUN    = 3'd2;
   localparam logic [STATE_W-1:0] ST_PAUSE  = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

   // Prescaler width: enough bits to hold 0..tick_div-1, never less than 1.
   function automatic int presc_width(input int tick_div);
      int w;
      w = $clog2(tick_div);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Prescaler for the countdown sequencer. Counts while en is high and wraps
// at TICK_DIV-1; wrap is the same-cycle wrap condition used by the FSM,
// tick is its registered copy for the outside world. clr has priority.
module countdown_tick_gen
   import countdown_pkg::*;
#(
   parameter int TICK_DIV = 25000000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic wrap,
   output logic tick
);

   localparam int PW = presc_width(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;

   assign wrap = en && !clr && (presc == LAST);

   // Prescaler register and registered tick pulse.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= wrap;
         if (clr)
            presc <= '0;
         else if (en)
            presc <= wrap ? '0 : presc + PW'(1);
      end
   end

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown sequencer: single-clock, enable-based down counter with
// load / start / pause control and a terminal-count pulse.
// Optional build macro: COUNTDOWN_AUTO_RELOAD_EN (count restarts from the
// last loaded value instead of finishing, when that value is non-zero).
//
// state  | meaning
// IDLE   | no count armed; waits for load
// LOADED | count holds a loaded value; waits for start
// RUN    | prescaler running, count decrements on each wrap
// PAUSE  | count and prescaler frozen; start resumes the partial period
// DONE   | terminal count reached; one cycle, done pulses on exit
// 5..7   | unreachable; fall back to IDLE
module countdown_sequencer
   import countdown_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 25000000
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               load,
   input  logic               start,
   input  logic               pause,
   input  logic [WIDTH-1:0]   load_val,
   output logic [WIDTH-1:0]   count,
   output logic               running,
   output logic               tick,
   output logic               done,
   output logic [STATE_W-1:0] state
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [STATE_W-1:0] state_nxt;
   logic [WIDTH-1:0]   count_nxt;
   logic               done_nxt;
   logic               presc_en;
   logic               presc_clr;
   logic               wrap;
   logic               reload_hit;

   // Prescaler runs only in RUN; a load or any non-counting state restarts
   // the period, PAUSE keeps the partial period.
   assign presc_en  = (state == ST_RUN) && !load;
   assign presc_clr = load || ((state != ST_RUN) && (state != ST_PAUSE));

   countdown_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .en       (presc_en),
      .clr      (presc_clr),
      .wrap     (wrap),
      .tick     (tick)
   );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;

   // Remember the last loaded value as the auto-reload target.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         reload_q <= '0;
      else if (load)
         reload_q <= load_val;
   end

   assign reload_hit = wrap && (count == CNT_ONE) && (reload_q != '0);
`else
   assign reload_hit = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         running <= (state_nxt == ST_RUN);
         done    <= done_nxt;
      end
   end

   // Next-state decode; priority load > pause > start.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (load)
               state_nxt = ST_LOADED;
         end
         ST_LOADED: begin
            if (load)
               state_nxt = ST_LOADED;
            else if (pause)
               state_nxt = ST_LOADED;
            else if (start)
               state_nxt = (count == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (load)
               state_nxt = ST_LOADED;
            else if (wrap && (count <= CNT_ONE) && !reload_hit)
               state_nxt = ST_DONE;
            else if (pause)
               state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (load)
               state_nxt = ST_LOADED;
            else if (pause)
               state_nxt = ST_PAUSE;
            else if (start)
               state_nxt = ST_RUN;
         end
         ST_DONE: begin
            state_nxt = load ? ST_LOADED : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next count and done pulse; done follows the single DONE cycle.
   always_comb begin
      count_nxt = count;
      done_nxt  = (state == ST_DONE) || reload_hit;
      case (state)
         ST_IDLE, ST_LOADED, ST_PAUSE: begin
            if (load)
               count_nxt = load_val;
         end
         ST_RUN: begin
            if (load)
               count_nxt = load_val;
            else if (wrap) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               if (reload_hit)
                  count_nxt = reload_q;
               else
`endif
               if (count > CNT_ONE)
                  count_nxt = count - CNT_ONE;
               else
                  count_nxt = '0;
            end
         end
         ST_DONE: begin
            count_nxt = load ? load_val : '0;
         end
         default: count_nxt = '0;
      endcase
   end

endmodule

// File: tb/tb_countdown_sequencer.sv
module tb_countdown_sequencer;

   localparam int WIDTH = 4;
   localparam int TD    = 4;

   logic             CLOCK_50 = 1'b0;
   logic             reset    = 1'b1;
   logic             load     = 1'b0;
   logic             start    = 1'b0;
   logic             pause    = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             tick;
   logic             done;
   logic [2:0]       state;

   int checks = 0;
   int errors = 0;

   countdown_sequencer #(.WIDTH(WIDTH), .TICK_DIV(TD)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .load     (load),
      .start    (start),
      .pause    (pause),
      .load_val (load_val),
      .count    (count),
      .running  (running),
      .tick     (tick),
      .done     (done),
      .state    (state)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Load n, start, optionally pause at edge p for d edges, then resume.
   // Expected values come from counting the edges spent running.
   task automatic run_scenario(input string tag, input int n, input bit use_pause,
                               input int p, input int d);
      int  rc, e_last, exp_cnt, exp_st;
      bit  run_e, exp_tick, exp_done;
      e_last = n * TD + (use_pause ? d : 0);
      load = 1; load_val = WIDTH'(n); start = 0; pause = 0;
      step();
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL %s load_state got=%0d exp=1", tag, state); end
      checks++; if (count !== WIDTH'(n)) begin errors++; $display("FAIL %s load_count got=%0d exp=%0d", tag, count, n); end
      load = 0; start = 1;
      step();
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL %s start_running got=%0d exp=1", tag, running); end
      start = 0;
      rc = 0;
      for (int e = 1; e <= e_last + 2; e++) begin
         pause = use_pause && (e >= p) && (e < p + d);
         start = use_pause && (e == p + d);
         step();
         run_e = !(use_pause && (e > p) && (e <= p + d)) && (e <= e_last);
         if (run_e) rc++;
         exp_cnt  = n - rc / TD;
         exp_tick = run_e && (rc % TD == 0);
         exp_done = (e == e_last + 1);
         if (e > e_last)                                 exp_st = 0;
         else if (e == e_last)                           exp_st = 4;
         else if (use_pause && (e >= p) && (e < p + d))  exp_st = 3;
         else                                            exp_st = 2;
         checks++; if (count !== WIDTH'(exp_cnt)) begin errors++; $display("FAIL %s count e=%0d got=%0d exp=%0d", tag, e, count, exp_cnt); end
         checks++; if (state !== 3'(exp_st)) begin errors++; $display("FAIL %s state e=%0d got=%0d exp=%0d", tag, e, state, exp_st); end
         checks++; if (running !== (exp_st == 2)) begin errors++; $display("FAIL %s running e=%0d got=%0d exp=%0d", tag, e, running, exp_st == 2); end
         checks++; if (tick !== exp_tick) begin errors++; $display("FAIL %s tick e=%0d got=%0d exp=%0d", tag, e, tick, exp_tick); end
         checks++; if (done !== exp_done) begin errors++; $display("FAIL %s done e=%0d got=%0d exp=%0d", tag, e, done, exp_done); end
      end
      pause = 0; start = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      step();
      step();
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if ({running, tick, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {running, tick, done}); end
      reset = 0; start = 1; pause = 1;
      step();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_ignores_start got=%0d exp=0", state); end
      start = 0; pause = 0;
   endtask

   task automatic test_countdown();
      run_scenario("countdown5", 5, 1'b0, 0, 0);
   endtask

   task automatic test_pause();
      run_scenario("pause3", 3, 1'b1, 6, 10);
   endtask

   task automatic test_random();
      int n, p, d;
      bit up;
      for (int t = 0; t < 8; t++) begin
         n  = $urandom_range(1, 15);
         up = 1'($urandom_range(0, 1));
         p  = $urandom_range(1, n * TD - 1);
         d  = $urandom_range(1, 6);
         run_scenario("random", n, up, p, d);
      end
   endtask

   task automatic test_zero_load();
      load = 1; load_val = '0;
      step();
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL zero_loaded got=%0d exp=1", state); end
      load = 0; start = 1;
      step();
      start = 0;
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL zero_done_state got=%0d exp=4", state); end
      checks++; if ({tick, done, running} !== 3'b000) begin errors++; $display("FAIL zero_flags1 got=%b exp=000", {tick, done, running}); end
      step();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL zero_idle got=%0d exp=0", state); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse got=%0d exp=1", done); end
      checks++; if ({count, tick} !== {WIDTH'(0), 1'b0}) begin errors++; $display("FAIL zero_count_tick got=%0d/%0d exp=0/0", count, tick); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_single got=%0d exp=0", done); end
   endtask

   task automatic test_load_in_run();
      load = 1; load_val = 4'd6;
      step();
      load = 0; start = 1;
      step();
      start = 0;
      for (int e = 1; e <= 11; e++) begin
         step();
         if (e == 8) begin
            checks++; if (count !== 4'd4) begin errors++; $display("FAIL lir_pre_count got=%0d exp=4", count); end
         end
      end
      // Edge 12 would be a prescaler wrap; the load must win.
      load = 1; load_val = 4'd9;
      step();
      load = 0;
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL lir_state got=%0d exp=1", state); end
      checks++; if (count !== 4'd9) begin errors++; $display("FAIL lir_count got=%0d exp=9", count); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL lir_tick got=%0d exp=0", tick); end
      start = 1;
      step();
      start = 0;
      for (int e = 1; e <= TD; e++) begin
         step();
         checks++; if (count !== ((e < TD) ? 4'd9 : 4'd8)) begin errors++; $display("FAIL lir_restart e=%0d got=%0d exp=%0d", e, count, (e < TD) ? 9 : 8); end
         checks++; if (tick !== (e == TD)) begin errors++; $display("FAIL lir_restart_tick e=%0d got=%0d exp=%0d", e, tick, e == TD); end
      end
   endtask

   task automatic test_async_reset();
      load = 1; load_val = 4'd6;
      step();
      load = 0; start = 1;
      step();
      start = 0;
      step();
      step();
      checks++; if ({state, count} !== {3'd2, 4'd6}) begin errors++; $display("FAIL ar_pre got=%0d/%0d exp=2/6", state, count); end
      #3 reset = 1;
      #1;
      checks++; if (count !== '0) begin errors++; $display("FAIL ar_count got=%0d exp=0", count); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL ar_state got=%0d exp=0", state); end
      checks++; if ({running, done, tick} !== 3'b000) begin errors++; $display("FAIL ar_flags got=%b exp=000", {running, done, tick}); end
      #1 reset = 0;
      for (int e = 0; e < 3 * TD; e++) begin
         step();
         checks++; if ({done, state} !== {1'b0, 3'd0}) begin errors++; $display("FAIL ar_after e=%0d got=%0d/%0d exp=0/0", e, done, state); end
      end
   endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      int exp_cnt;
      load = 1; load_val = 4'd2;
      step();
      load = 0; start = 1;
      step();
      start = 0;
      for (int e = 1; e <= 24; e++) begin
         step();
         exp_cnt = 2 - ((e / TD) % 2);
         checks++; if (count !== WIDTH'(exp_cnt)) begin errors++; $display("FAIL auto_count e=%0d got=%0d exp=%0d", e, count, exp_cnt); end
         checks++; if (done !== (e % (2 * TD) == 0)) begin errors++; $display("FAIL auto_done e=%0d got=%0d exp=%0d", e, done, e % (2 * TD) == 0); end
         checks++; if (running !== 1'b1) begin errors++; $display("FAIL auto_running e=%0d got=%0d exp=1", e, running); end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      test_auto_reload();
`else
      test_countdown();
      test_pause();
      test_random();
`endif
      test_zero_load();
      test_load_in_run();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
